// File: rtl/game_pkg.sv
// Shared types and widths for the runner-game control slice.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int SPEED_W = 4;
    localparam int POS_W   = 6;
    localparam int SCORE_W = 14;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;

endpackage

// File: rtl/game_ctrl_if.sv
// Button/collision inputs and game-state outputs between game_ctrl and the datapath.
interface game_ctrl_if;
    import game_pkg::*;

    logic               btn_jump;
    logic               collision;
    logic               game_status;
    logic               game_over;
    logic [SPEED_W-1:0] speed;
    logic [POS_W-1:0]   ground_position;
    logic [SCORE_W-1:0] score;
    logic               tick;
    logic               jump_start;

    modport master (
        input  btn_jump, collision,
        output game_status, game_over, speed, ground_position, score, tick, jump_start
    );

    modport slave (
        output btn_jump, collision,
        input  game_status, game_over, speed, ground_position, score, tick, jump_start
    );

endinterface

// File: rtl/game_ctrl_tick_gen.sv
// Free-running divider: one-cycle registered pulse every TICK_DIV clocks.
module tick_gen #(
    parameter int unsigned TICK_DIV = 500000
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == LAST);
            r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: IDLE/RUN/OVER state machine, scoring, speed ramp and ground scroll.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 500000,
    parameter int unsigned SPEED_INIT = 4,
    parameter int unsigned SPEED_MAX  = 15,
    parameter int unsigned SCORE_STEP = 100,
    parameter int unsigned HOLDOFF    = 50
) (
    input  logic       CLK,
    input  logic       RST,
    game_ctrl_if.master bus
);

    localparam int unsigned HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam int unsigned SW = $clog2(SCORE_STEP + 1);

    localparam logic [SPEED_W-1:0] SPD_INIT  = SPEED_W'(SPEED_INIT);
    localparam logic [SPEED_W-1:0] SPD_MAX   = SPEED_W'(SPEED_MAX);
    localparam logic [HW-1:0]      HOLD_MAX  = HW'(HOLDOFF);
    localparam logic [SW-1:0]      STEP_LAST = SW'(SCORE_STEP - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_btn_prev;
    logic               r_jump;
    logic [SPEED_W-1:0] r_speed;
    logic [POS_W-1:0]   r_pos;
    logic [SCORE_W-1:0] r_score;
    logic [SW-1:0]      r_step;
    logic [HW-1:0]      r_holdoff;

    logic w_tick;
    logic w_rise;
    logic w_start;
    logic w_advance;
    logic w_jump;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .tick (w_tick)
    );

    assign w_rise = bus.btn_jump & ~r_btn_prev;

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Collision in RUN pre-empts both the tick update and any jump request.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_advance    = 1'b0;
        w_jump       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_next = ST_RUN;
                    w_start      = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.collision) begin
                    w_state_next = ST_OVER;
                end else begin
                    w_advance = w_tick;
                    w_jump    = w_rise;
                end
            end
            ST_OVER: begin
                if (w_rise && (r_holdoff == HOLD_MAX)) begin
                    w_state_next = ST_RUN;
                    w_start      = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_btn_prev <= 1'b0;
            r_jump     <= 1'b0;
            r_speed    <= SPD_INIT;
            r_pos      <= '0;
            r_score    <= '0;
            r_step     <= '0;
            r_holdoff  <= '0;
        end else begin
            r_btn_prev <= bus.btn_jump;
            r_jump     <= w_jump;
            if (w_start) begin
                r_speed   <= SPD_INIT;
                r_pos     <= '0;
                r_score   <= '0;
                r_step    <= '0;
                r_holdoff <= '0;
            end else if (w_advance) begin
                r_pos   <= r_pos + POS_W'(r_speed);
                r_score <= (r_score == SCORE_MAX) ? r_score : r_score + 1'b1;
                if (r_step == STEP_LAST) begin
                    r_step  <= '0;
                    r_speed <= (r_speed >= SPD_MAX) ? r_speed : r_speed + 1'b1;
                end else begin
                    r_step <= r_step + 1'b1;
                end
            end else if ((r_state == ST_OVER) && w_tick && (r_holdoff != HOLD_MAX)) begin
                r_holdoff <= r_holdoff + 1'b1;
            end
        end
    end

    assign bus.game_status     = (r_state == ST_RUN);
    assign bus.game_over       = (r_state == ST_OVER);
    assign bus.speed           = r_speed;
    assign bus.ground_position = r_pos;
    assign bus.score           = r_score;
    assign bus.tick            = w_tick;
    assign bus.jump_start      = r_jump;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with TICK_DIV=4, SCORE_STEP=3, HOLDOFF=2, SPEED_MAX=6.
module tb_game_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    game_ctrl_if bus();

    game_ctrl #(
        .TICK_DIV   (4),
        .SPEED_INIT (4),
        .SPEED_MAX  (6),
        .SCORE_STEP (3),
        .HOLDOFF    (2)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance until tick is visible; a missing tick within 8 cycles is a failure.
    task automatic wait_tick();
        int n;
        n = 0;
        while (bus.tick !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        if (bus.tick !== 1'b1) check("tick_timeout", 32'(bus.tick), 32'd1);
    endtask

    task automatic run_ticks(input int count);
        for (int i = 0; i < count; i++) begin
            wait_tick();
            step();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_status"}, 32'(bus.game_status), 32'd0);
        check({tag, "_over"},   32'(bus.game_over), 32'd0);
        check({tag, "_speed"},  32'(bus.speed), 32'd4);
        check({tag, "_pos"},    32'(bus.ground_position), 32'd0);
        check({tag, "_score"},  32'(bus.score), 32'd0);
        check({tag, "_tick"},   32'(bus.tick), 32'd0);
        check({tag, "_jump"},   32'(bus.jump_start), 32'd0);
    endtask

    initial begin
        int n;
        bus.btn_jump  = 1'b0;
        bus.collision = 1'b0;

        // 1. Reset, tick spacing and idle outputs
        rst = 1'b1;
        step();
        check_reset_values("rst");
        rst = 1'b0;
        n = 0;
        do begin step(); n++; end while (bus.tick !== 1'b1 && n < 10);
        check("first_tick_latency", 32'(n), 32'd4);
        n = 0;
        do begin step(); n++; end while (bus.tick !== 1'b1 && n < 10);
        check("tick_period", 32'(n), 32'd4);
        for (int i = 0; i < 12; i++) step();
        check("idle_status", 32'(bus.game_status), 32'd0);
        check("idle_score", 32'(bus.score), 32'd0);

        // 2. Start press, then 16 ticks of scrolling
        bus.btn_jump = 1'b1;
        step();
        check("start_status", 32'(bus.game_status), 32'd1);
        check("start_jump", 32'(bus.jump_start), 32'd0);
        bus.btn_jump = 1'b0;
        step();
        check("start_jump_late", 32'(bus.jump_start), 32'd0);
        run_ticks(16);
        check("run16_pos", 32'(bus.ground_position), 32'd23);
        check("run16_score", 32'(bus.score), 32'd16);
        check("run16_speed_sat", 32'(bus.speed), 32'd6);

        // 3. Jump pulse is a single cycle even with the button held
        bus.btn_jump = 1'b1;
        step();
        check("jump_pulse", 32'(bus.jump_start), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("jump_held", 32'(bus.jump_start), 32'd0);
        end
        bus.btn_jump = 1'b0;
        step();

        // Reset mid-RUN, then a fresh game for the collision case
        check("pre_reset_status", 32'(bus.game_status), 32'd1);
        rst = 1'b1;
        step();
        check_reset_values("midrun_rst");
        rst = 1'b0;
        step();
        bus.btn_jump = 1'b1;
        step();
        bus.btn_jump = 1'b0;
        check("restart_status", 32'(bus.game_status), 32'd1);
        run_ticks(7);
        check("run7_score", 32'(bus.score), 32'd7);
        check("run7_pos", 32'(bus.ground_position), 32'd33);

        // 4. Collision coincident with a tick
        wait_tick();
        bus.collision = 1'b1;
        step();
        bus.collision = 1'b0;
        check("coll_over", 32'(bus.game_over), 32'd1);
        check("coll_status", 32'(bus.game_status), 32'd0);
        check("coll_score", 32'(bus.score), 32'd7);
        check("coll_pos", 32'(bus.ground_position), 32'd33);
        check("coll_speed", 32'(bus.speed), 32'd6);

        // 5. Holdoff: first rise after one tick is ignored, after two it restarts
        run_ticks(1);
        bus.btn_jump = 1'b1;
        step();
        bus.btn_jump = 1'b0;
        step();
        check("early_rise_over", 32'(bus.game_over), 32'd1);
        check("early_rise_score", 32'(bus.score), 32'd7);
        run_ticks(1);
        bus.btn_jump = 1'b1;
        step();
        bus.btn_jump = 1'b0;
        check("late_rise_status", 32'(bus.game_status), 32'd1);
        check("late_rise_over", 32'(bus.game_over), 32'd0);
        check("late_rise_score", 32'(bus.score), 32'd0);
        check("late_rise_speed", 32'(bus.speed), 32'd4);
        check("late_rise_pos", 32'(bus.ground_position), 32'd0);
        check("late_rise_jump", 32'(bus.jump_start), 32'd0);

        // 6. Score saturation and final reset
        run_ticks(9998);
        check("score_9998", 32'(bus.score), 32'd9998);
        run_ticks(3);
        check("score_sat", 32'(bus.score), 32'd9999);
        check("sat_status", 32'(bus.game_status), 32'd1);
        rst = 1'b1;
        step();
        check_reset_values("final_rst");
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
